// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pattern pipeline stage.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEFAULT = 640;
  localparam int unsigned V_ACTIVE_DEFAULT = 480;
  localparam int unsigned COORD_W          = 10;
  localparam int unsigned BOX_W            = 11;
  localparam int unsigned MODE_W           = 2;
  localparam int unsigned RGB_W            = 6;

  typedef enum logic [MODE_W-1:0] {
    MODE_WHITE = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  // {r1,r0,g1,g0,b1,b0}
  typedef logic [RGB_W-1:0] rgb_t;

  localparam rgb_t WHITE = 6'b11_11_11;
  localparam rgb_t BLACK = 6'b00_00_00;
  localparam rgb_t RED   = 6'b11_00_00;
  localparam rgb_t GREEN = 6'b00_11_00;
  localparam rgb_t BLUE  = 6'b00_00_11;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

  typedef struct packed {
    logic [BOX_W-1:0] pos;
    dir_e             dir;
  } axis_t;

  // One bounce step on one axis; a reversal holds position for that frame.
  function automatic axis_t bounce(input axis_t cur, input logic [BOX_W-1:0] hi,
                                   input logic [BOX_W-1:0] step);
    axis_t nxt;
    nxt = cur;
    if (cur.dir == DIR_POS) begin
      if (cur.pos + step > hi) nxt.dir = DIR_NEG;
      else                     nxt.pos = cur.pos + step;
    end else begin
      if (cur.pos < step) nxt.dir = DIR_POS;
      else                nxt.pos = cur.pos - step;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position state: each axis steps or reverses once per frame start.
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEFAULT,
  parameter int unsigned BOX_SIZE = 32,
  parameter int unsigned BOX_STEP = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             frame_start,
  output logic [BOX_W-1:0] box_x,
  output logic [BOX_W-1:0] box_y
);

  localparam logic [BOX_W-1:0] X_HI = BOX_W'(H_ACTIVE - BOX_SIZE);
  localparam logic [BOX_W-1:0] Y_HI = BOX_W'(V_ACTIVE - BOX_SIZE);
  localparam logic [BOX_W-1:0] STEP = BOX_W'(BOX_STEP);

  axis_t ax_q, ax_d, ay_q, ay_d;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      ax_q <= '{pos: '0, dir: DIR_POS};
      ay_q <= '{pos: '0, dir: DIR_POS};
    end else begin
      ax_q <= ax_d;
      ay_q <= ay_d;
    end
  end

  always_comb begin
    ax_d = ax_q;
    ay_d = ay_q;
    if (frame_start) begin
      ax_d = bounce(ax_q, X_HI, STEP);
      ay_d = bounce(ay_q, Y_HI, STEP);
    end
  end

  assign box_x = ax_q.pos;
  assign box_y = ay_q.pos;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern colour stage behind vga_sync; rebuilds x/y from the sync stream.
// Define VGA_PATTERN_BORDER_EN to paint a red one-pixel frame around the active area.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE        = H_ACTIVE_DEFAULT,
  parameter int unsigned V_ACTIVE        = V_ACTIVE_DEFAULT,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned CHECK_LOG2      = 5,
  parameter int unsigned BOX_SIZE        = 32,
  parameter int unsigned BOX_STEP        = 2
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  input  logic              display_en_in,
  input  logic [MODE_W-1:0] mode,
  output logic [1:0]        r,
  output logic [1:0]        g,
  output logic [1:0]        b,
  output logic              h_sync,
  output logic              v_sync,
  output logic              display_en
);

  localparam logic               SYNC_IDLE = SYNC_ACTIVE_LOW;
  localparam logic [COORD_W-1:0] X_MAX     = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_MAX     = COORD_W'(V_ACTIVE - 1);
  localparam logic [COORD_W-1:0] BAR_LAST  = COORD_W'(H_ACTIVE / 8 - 1);
  localparam logic [BOX_W-1:0]   BOX_LEN   = BOX_W'(BOX_SIZE);

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d, bar_cnt_q, bar_cnt_d;
  logic [2:0]         bar_idx_q, bar_idx_d;
  mode_e              mode_q, mode_d;
  rgb_t               rgb_q, rgb_d;
  logic               h_sync_q, v_sync_q, display_en_q;
  logic               frame_start_c, de_fall_c, in_box_c;
  logic [BOX_W-1:0]   box_x, box_y;

  // The delayed sync/enable flops double as the edge-detect history.
  assign frame_start_c = (v_sync_in != SYNC_IDLE) && (v_sync_q == SYNC_IDLE);
  assign de_fall_c     = display_en_q && !display_en_in;

  vga_box_mover #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BOX_SIZE (BOX_SIZE),
    .BOX_STEP (BOX_STEP)
  ) u_box_mover (
    .clk_in      (clk_in),
    .reset       (reset),
    .frame_start (frame_start_c),
    .box_x       (box_x),
    .box_y       (box_y)
  );

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      x_q          <= '0;
      y_q          <= '0;
      bar_cnt_q    <= '0;
      bar_idx_q    <= '0;
      mode_q       <= MODE_WHITE;
      rgb_q        <= BLACK;
      h_sync_q     <= SYNC_IDLE;
      v_sync_q     <= SYNC_IDLE;
      display_en_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      bar_cnt_q    <= bar_cnt_d;
      bar_idx_q    <= bar_idx_d;
      mode_q       <= mode_d;
      rgb_q        <= rgb_d;
      h_sync_q     <= h_sync_in;
      v_sync_q     <= v_sync_in;
      display_en_q <= display_en_in;
    end
  end

  // Pixel position and bar tracking
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    mode_d    = frame_start_c ? mode_e'(mode) : mode_q;
    if (de_fall_c) begin
      x_d       = '0;
      bar_cnt_d = '0;
      bar_idx_d = '0;
    end else if (display_en_in) begin
      if (x_q != X_MAX) x_d = x_q + COORD_W'(1);
      if (bar_cnt_q == BAR_LAST) begin
        bar_cnt_d = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + COORD_W'(1);
      end
    end
    if (frame_start_c)                  y_d = '0;
    else if (de_fall_c && y_q != Y_MAX) y_d = y_q + COORD_W'(1);
  end

  assign in_box_c = ({1'b0, x_q} >= box_x) && ({1'b0, x_q} < box_x + BOX_LEN) &&
                    ({1'b0, y_q} >= box_y) && ({1'b0, y_q} < box_y + BOX_LEN);

  // Colour for the pixel currently on the inputs
  always_comb begin
    rgb_d = BLACK;
    if (display_en_in) begin
      case (mode_q)
        MODE_WHITE: rgb_d = WHITE;
        MODE_BARS:  rgb_d = {{2{~bar_idx_q[2]}}, {2{~bar_idx_q[1]}}, {2{~bar_idx_q[0]}}};
        MODE_CHECK: rgb_d = (x_q[CHECK_LOG2] ^ y_q[CHECK_LOG2]) ? WHITE : BLACK;
        MODE_BOX:   rgb_d = in_box_c ? GREEN : BLUE;
        default:    rgb_d = BLACK;
      endcase
`ifdef VGA_PATTERN_BORDER_EN
      if (x_q == '0 || x_q == X_MAX || y_q == '0 || y_q == Y_MAX) rgb_d = RED;
`else
`endif
    end
  end

  assign r          = rgb_q[5:4];
  assign g          = rgb_q[3:2];
  assign b          = rgb_q[1:0];
  assign h_sync     = h_sync_q;
  assign v_sync     = v_sync_q;
  assign display_en = display_en_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomised frame-level bench for vga_pattern_gen on a reduced raster.
module tb_vga_pattern_gen;

  localparam int H     = 32;
  localparam int V     = 16;
  localparam int HT    = 40;
  localparam int VT    = 20;
  localparam int CL    = 2;
  localparam int BS    = 8;
  localparam int BSTEP = 2;
  localparam int NF    = 40;
  localparam int RST_F = 30;

  // white, yellow, magenta, red, cyan, green, blue, black
  localparam logic [5:0] BAR_RGB [8] = '{6'h3F, 6'h3C, 6'h33, 6'h30, 6'h0F, 6'h0C, 6'h03, 6'h00};

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       h_sync_in = 1'b1;
  logic       v_sync_in = 1'b1;
  logic       display_en_in = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [1:0] r, g, b;
  logic       h_sync, v_sync, display_en;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int mode_m, bx, by, max_bx, max_by;
  bit bx_pos, by_pos, valid, prev_vs;

  always #5 clk_in = ~clk_in;

  vga_pattern_gen #(
    .H_ACTIVE        (H),
    .V_ACTIVE        (V),
    .SYNC_ACTIVE_LOW (1'b1),
    .CHECK_LOG2      (CL),
    .BOX_SIZE        (BS),
    .BOX_STEP        (BSTEP)
  ) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .h_sync_in     (h_sync_in),
    .v_sync_in     (v_sync_in),
    .display_en_in (display_en_in),
    .mode          (mode),
    .r             (r),
    .g             (g),
    .b             (b),
    .h_sync        (h_sync),
    .v_sync        (v_sync),
    .display_en    (display_en)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] model_rgb(input int x, input int y, input int md,
                                           input int px, input int py);
    logic [5:0] c;
    case (md)
      0:       c = 6'h3F;
      1:       c = BAR_RGB[(x / (H / 8)) % 8];
      2:       c = ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? 6'h3F : 6'h00;
      default: c = (x >= px && x < px + BS && y >= py && y < py + BS) ? 6'h0C : 6'h03;
    endcase
`ifdef VGA_PATTERN_BORDER_EN
    if (x == 0 || x == H - 1 || y == 0 || y == V - 1) c = 6'h30;
`else
`endif
    return c;
  endfunction

  task automatic move_axis(inout int p, inout bit pos, input int lim);
    if (pos) begin
      if (p + BSTEP > lim - BS) pos = 1'b0;
      else                      p   = p + BSTEP;
    end else begin
      if (p < BSTEP) pos = 1'b1;
      else           p   = p - BSTEP;
    end
  endtask

  task automatic model_reset();
    mode_m = 0; bx = 0; by = 0; bx_pos = 1'b1; by_pos = 1'b1;
    valid = 1'b0; prev_vs = 1'b1;
  endtask

  // Drive one pixel clock, predict the registered outputs, check them after the edge.
  task automatic pix(input bit rst, input bit hs, input bit vs, input bit de,
                     input logic [1:0] md, input int x, input int y);
    logic [8:0] exp;
    logic [8:0] obs;
    bit         full;
    reset = rst; h_sync_in = hs; v_sync_in = vs; display_en_in = de; mode = md;
    if (rst) begin
      model_reset();
      exp  = 9'b000000_110;
      full = 1'b1;
    end else begin
      exp  = {de ? model_rgb(x, y, mode_m, bx, by) : 6'h00, hs, vs, de};
      full = valid || !de;
      if (prev_vs && !vs) begin
        mode_m = int'(md);
        move_axis(bx, bx_pos, H);
        move_axis(by, by_pos, V);
        valid = 1'b1;
      end
      prev_vs = vs;
    end
    @(posedge clk_in);
    #1;
    obs = {r, g, b, h_sync, v_sync, display_en};
    if (rst)       check_eq("reset_out", 32'(obs), 32'(exp));
    else if (full) check_eq($sformatf("pix x%0d y%0d m%0d", x, y, mode_m), 32'(obs), 32'(exp));
    else           check_eq($sformatf("sync x%0d y%0d", x, y), 32'(obs[2:0]), 32'(exp[2:0]));
  endtask

  initial begin
    logic [1:0] md;
    int         l;
    model_reset();
    max_bx = 0; max_by = 0;
    md = 2'd0;
    for (int i = 0; i < 3; i++) pix(1'b1, 1'b1, 1'b1, 1'b0, md, 0, 0);
    for (int f = 0; f < NF; f++) begin
      // each frame: blanking lines (with vsync) first, then the active area
      for (int ll = 0; ll < VT; ll++) begin
        l = (ll + V) % VT;
        for (int c = 0; c < HT; c++) begin
          if (l == V && c == 0)     md = (f < 4) ? 2'(f) : 2'($urandom_range(0, 3));
          if (l == V / 2 && c == 0) md = 2'($urandom_range(0, 3));
          pix(f == RST_F && l == 5 && c >= 10 && c < 13,
              !(c >= H + 2 && c < H + 6),
              !(l == V + 1 || l == V + 2),
              (c < H) && (l < V), md, c, l);
        end
      end
      check_eq($sformatf("box_x f%0d", f), 32'(dut.u_box_mover.box_x), 32'(bx));
      check_eq($sformatf("box_y f%0d", f), 32'(dut.u_box_mover.box_y), 32'(by));
      if (int'(dut.u_box_mover.box_x) > max_bx) max_bx = int'(dut.u_box_mover.box_x);
      if (int'(dut.u_box_mover.box_y) > max_by) max_by = int'(dut.u_box_mover.box_y);
    end
    check_eq("box_x_peak", 32'(max_bx), 32'(H - BS));
    check_eq("box_y_peak", 32'(max_by), 32'(V - BS));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
